// File: rtl/serial_parity_rx.sv
// Over-sampled serial even-parity frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Latency: CLKS_PER_BIT/2 + (DATA_W+2)*CLKS_PER_BIT + 1 cycles from rx_s falling to valid; no backpressure.
module serial_parity_rx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TMR_W-1:0] HALF_M1  = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] FULL_M1  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               rx_meta;
  logic               rx_s;
  logic [TMR_W-1:0]   timer;
  logic [IDX_W-1:0]   bit_idx;
  logic [DATA_W-1:0]  shift_reg;
  logic               parity_bit;
  logic               armed;
  logic               tick;
  logic               stop_tick;

  // tick marks the cycle whose rx_s value is the mid-bit sample of the current bit
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    stop_tick = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !rx_s) state_nxt = START;
      end
      START: begin
        tick = (timer == HALF_M1);
        if (tick) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        tick = (timer == FULL_M1);
        if (tick && (bit_idx == LAST_IDX)) state_nxt = PARITY;
      end
      PARITY: begin
        tick = (timer == FULL_M1);
        if (tick) state_nxt = STOP;
      end
      STOP: begin
        tick      = (timer == FULL_M1);
        stop_tick = tick;
        if (tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      armed      <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      state   <= state_nxt;
      valid   <= stop_tick;

      if ((state == IDLE) || tick) timer <= '0;
      else                         timer <= timer + TMR_W'(1);

      if (state != DATA) bit_idx <= '0;
      else if (tick)     bit_idx <= bit_idx + IDX_W'(1);

      if ((state == DATA) && tick)
        shift_reg <= (shift_reg >> 1) | (DATA_W'(rx_s) << (DATA_W - 1));

      if ((state == PARITY) && tick) parity_bit <= rx_s;

      // A high stop sample re-arms immediately so a back-to-back start edge is never missed
      if (state == IDLE) begin
        if (state_nxt != IDLE) armed <= 1'b0;
        else if (rx_s)         armed <= 1'b1;
      end else if (stop_tick && rx_s) begin
        armed <= 1'b1;
      end

      if (stop_tick) begin
        data       <= shift_reg;
        parity_err <= ^{shift_reg, parity_bit};
        frame_err  <= ~rx_s;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
